// File: rtl/rename_allocator.sv
// rename_allocator
//   In-order rename tag allocator for a two-wide decode/commit pipeline.
//   Tags 1..TAGS are handed out from a circular pointer (alloc_ptr) and must
//   be returned in the same order (free_ptr). Tag 0 is reserved for
//   "no rename". A protocol violation on the free side sets a sticky panic
//   flag that blocks all further grants until reset.
//
// Ports
//   i_clock        clock, rising edge
//   i_reset_n      synchronous active-low reset
//   i_alloc_req    [1:0] per-slot allocation request
//   o_alloc_tag_0  tag offered to slot 0
//   o_alloc_tag_1  tag offered to slot 1
//   o_alloc_grant  all requested slots receive their offered tags
//   o_stall        request pending but not granted
//   i_free_valid   [1:0] per-commit-port free strobe
//   i_free_tag_0   tag returned on commit port 0
//   i_free_tag_1   tag returned on commit port 1
//   i_flush        reclaim every outstanding tag
//   i_halt         block allocation (frees/flush still act)
//   o_free_count   registered number of free tags
//   o_panic        sticky protocol-error flag
module rename_allocator #(
   parameter int unsigned TAGS = 63
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic [1:0] i_alloc_req,
   output logic [5:0] o_alloc_tag_0,
   output logic [5:0] o_alloc_tag_1,
   output logic       o_alloc_grant,
   output logic       o_stall,
   input  logic [1:0] i_free_valid,
   input  logic [5:0] i_free_tag_0,
   input  logic [5:0] i_free_tag_1,
   input  logic       i_flush,
   input  logic       i_halt,
   output logic [6:0] o_free_count,
   output logic       o_panic
);

   localparam logic [5:0] LAST_PTR = 6'(TAGS - 1);
   localparam logic [6:0] TAGS_CNT = 7'(TAGS);

   logic [5:0] alloc_ptr_q, alloc_ptr_d;
   logic [5:0] free_ptr_q,  free_ptr_d;
   logic [6:0] free_count_q, free_count_d;
   logic       panic_q, panic_d;

   logic [1:0] need;
   logic [1:0] accepted;
   logic       free_err;
   logic [5:0] fp_w;
   logic [6:0] fc_w;
   logic [5:0] free_tag [2];

   function automatic logic [5:0] ptr_inc(input logic [5:0] p);
      return (p == LAST_PTR) ? '0 : p + 6'd1;
   endfunction

   // Offers and grant decision depend only on registered state and the
   // current request; frees of this cycle never feed the grant.
   always_comb begin
      need          = {1'b0, i_alloc_req[0]} + {1'b0, i_alloc_req[1]};
      o_alloc_tag_0 = alloc_ptr_q + 6'd1;
      o_alloc_tag_1 = (i_alloc_req == 2'b11) ? ptr_inc(alloc_ptr_q) + 6'd1
                                             : alloc_ptr_q + 6'd1;
      o_alloc_grant = !i_halt && !i_flush && !panic_q && (need != 2'd0) &&
                      (free_count_q >= {5'b0, need});
      o_stall       = (i_alloc_req != 2'b00) && !o_alloc_grant;
      o_free_count  = free_count_q;
      o_panic       = panic_q;
   end

   // Commit ports are applied in order: port 1 is checked against the free
   // pointer as already advanced by an accepted port-0 free. A rejected free
   // leaves pointer and count untouched and only raises the error.
   always_comb begin
      free_tag[0] = i_free_tag_0;
      free_tag[1] = i_free_tag_1;
      fp_w        = free_ptr_q;
      fc_w        = free_count_q;
      accepted    = '0;
      free_err    = 1'b0;
      for (int unsigned k = 0; k < 2; k++) begin
         if (i_free_valid[k]) begin
            if ((fc_w == TAGS_CNT) || (free_tag[k] != fp_w + 6'd1)) begin
               free_err = 1'b1;
            end else begin
               fp_w     = ptr_inc(fp_w);
               fc_w     = fc_w + 7'd1;
               accepted = accepted + 2'd1;
            end
         end
      end
   end

   always_comb begin
      alloc_ptr_d  = alloc_ptr_q;
      free_ptr_d   = fp_w;
      free_count_d = free_count_q + {5'b0, accepted};
      panic_d      = panic_q | free_err;
      if (i_flush) begin
         alloc_ptr_d  = fp_w;
         free_count_d = TAGS_CNT;
      end else if (o_alloc_grant) begin
         alloc_ptr_d  = (need == 2'd2) ? ptr_inc(ptr_inc(alloc_ptr_q))
                                       : ptr_inc(alloc_ptr_q);
         free_count_d = free_count_q - {5'b0, need} + {5'b0, accepted};
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         alloc_ptr_q  <= '0;
         free_ptr_q   <= '0;
         free_count_q <= TAGS_CNT;
         panic_q      <= 1'b0;
      end else begin
         alloc_ptr_q  <= alloc_ptr_d;
         free_ptr_q   <= free_ptr_d;
         free_count_q <= free_count_d;
         panic_q      <= panic_d;
      end
   end

endmodule

// File: tb/tb_rename_allocator.sv
module tb_rename_allocator;

   logic       clk;
   logic       rst_n;
   logic [1:0] req;
   logic [5:0] tag0, tag1;
   logic       grant, stall;
   logic [1:0] fvalid;
   logic [5:0] ftag0, ftag1;
   logic       flush, halt;
   logic [6:0] fcount;
   logic       panic;

   int total = 0;
   int bad   = 0;

   rename_allocator #(.TAGS(63)) dut (
      .i_clock      (clk),
      .i_reset_n    (rst_n),
      .i_alloc_req  (req),
      .o_alloc_tag_0(tag0),
      .o_alloc_tag_1(tag1),
      .o_alloc_grant(grant),
      .o_stall      (stall),
      .i_free_valid (fvalid),
      .i_free_tag_0 (ftag0),
      .i_free_tag_1 (ftag1),
      .i_flush      (flush),
      .i_halt       (halt),
      .o_free_count (fcount),
      .o_panic      (panic)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      req = 2'b00; fvalid = 2'b00; ftag0 = '0; ftag1 = '0;
      flush = 1'b0; halt = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      // dirty state first so reset has something to clear
      rst_n = 1'b1; idle();
      step();
      req = 2'b11; step(); idle();
      do_reset();
      #2;
      total++; if (tag0 !== 6'd1) begin bad++; $display("FAIL reset_tag0 got=%0d exp=1", tag0); end
      total++; if (tag1 !== 6'd1) begin bad++; $display("FAIL reset_tag1 got=%0d exp=1", tag1); end
      total++; if (grant !== 1'b0) begin bad++; $display("FAIL reset_grant got=%0b exp=0", grant); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall); end
      total++; if (fcount !== 7'd63) begin bad++; $display("FAIL reset_count got=%0d exp=63", fcount); end
      total++; if (panic !== 1'b0) begin bad++; $display("FAIL reset_panic got=%0b exp=0", panic); end
   endtask

   task automatic test_fill_empty();
      do_reset();
      for (int i = 0; i < 31; i++) begin
         req = 2'b11; #2;
         total++; if (tag0 !== 6'(2*i+1) || tag1 !== 6'(2*i+2) || grant !== 1'b1) begin
            bad++; $display("FAIL fill_pair%0d got=(%0d,%0d,g%0b) exp=(%0d,%0d,g1)", i, tag0, tag1, grant, 2*i+1, 2*i+2);
         end
         step();
      end
      idle(); #2;
      total++; if (fcount !== 7'd1) begin bad++; $display("FAIL fill_count got=%0d exp=1", fcount); end
      req = 2'b11; #2;
      total++; if (stall !== 1'b1 || grant !== 1'b0) begin bad++; $display("FAIL fill_pair_stall got=s%0b g%0b exp=s1 g0", stall, grant); end
      step();
      total++; if (fcount !== 7'd1) begin bad++; $display("FAIL fill_no_consume got=%0d exp=1", fcount); end
      req = 2'b01; #2;
      total++; if (tag0 !== 6'd63 || grant !== 1'b1) begin bad++; $display("FAIL fill_last got=%0d g%0b exp=63 g1", tag0, grant); end
      step();
      total++; if (fcount !== 7'd0) begin bad++; $display("FAIL fill_empty_count got=%0d exp=0", fcount); end
      #2;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL empty_stall got=%0b exp=1", stall); end
   endtask

   // continues from empty state left by test_fill_empty
   task automatic test_same_cycle();
      req = 2'b01; fvalid = 2'b01; ftag0 = 6'd1; #2;
      total++; if (stall !== 1'b1 || grant !== 1'b0) begin bad++; $display("FAIL same_stall got=s%0b g%0b exp=s1 g0", stall, grant); end
      step();
      fvalid = 2'b00; #2;
      total++; if (fcount !== 7'd1) begin bad++; $display("FAIL same_count1 got=%0d exp=1", fcount); end
      total++; if (tag0 !== 6'd1 || grant !== 1'b1) begin bad++; $display("FAIL same_offer got=%0d g%0b exp=1 g1", tag0, grant); end
      step(); idle(); #2;
      total++; if (fcount !== 7'd0) begin bad++; $display("FAIL same_count0 got=%0d exp=0", fcount); end
      total++; if (panic !== 1'b0) begin bad++; $display("FAIL same_panic got=%0b exp=0", panic); end
   endtask

   task automatic test_wrap();
      do_reset();
      req = 2'b11;
      for (int i = 0; i < 31; i++) step();
      req = 2'b00;
      for (int i = 0; i < 31; i++) begin
         fvalid = 2'b11; ftag0 = 6'(2*i+1); ftag1 = 6'(2*i+2);
         step();
      end
      idle(); #2;
      total++; if (fcount !== 7'd63 || panic !== 1'b0) begin bad++; $display("FAIL wrap_drained got=%0d p%0b exp=63 p0", fcount, panic); end
      req = 2'b11; #2;
      total++; if (tag0 !== 6'd63 || tag1 !== 6'd1 || grant !== 1'b1) begin
         bad++; $display("FAIL wrap_offer got=(%0d,%0d,g%0b) exp=(63,1,g1)", tag0, tag1, grant);
      end
      step();
      req = 2'b00; fvalid = 2'b11; ftag0 = 6'd63; ftag1 = 6'd1;
      step(); idle(); #2;
      total++; if (fcount !== 7'd63 || panic !== 1'b0) begin bad++; $display("FAIL wrap_free got=%0d p%0b exp=63 p0", fcount, panic); end
      total++; if (tag0 !== 6'd2) begin bad++; $display("FAIL wrap_next got=%0d exp=2", tag0); end
   endtask

   task automatic test_flush();
      do_reset();
      req = 2'b11;
      for (int i = 0; i < 5; i++) step();
      req = 2'b00; fvalid = 2'b11; ftag0 = 6'd1; ftag1 = 6'd2; step();
      fvalid = 2'b01; ftag0 = 6'd3; step();
      idle(); #2;
      total++; if (fcount !== 7'd56) begin bad++; $display("FAIL flush_pre_count got=%0d exp=56", fcount); end
      flush = 1'b1; fvalid = 2'b01; ftag0 = 6'd4; req = 2'b01; #2;
      total++; if (grant !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL flush_no_grant got=g%0b s%0b exp=g0 s1", grant, stall); end
      step(); idle(); #2;
      total++; if (fcount !== 7'd63 || panic !== 1'b0) begin bad++; $display("FAIL flush_count got=%0d p%0b exp=63 p0", fcount, panic); end
      req = 2'b01; #2;
      total++; if (tag0 !== 6'd5 || grant !== 1'b1) begin bad++; $display("FAIL flush_offer got=%0d g%0b exp=5 g1", tag0, grant); end
      step(); idle();
   endtask

   task automatic test_errors();
      do_reset();
      req = 2'b11;
      for (int i = 0; i < 3; i++) step();
      req = 2'b00; fvalid = 2'b11; ftag0 = 6'd1; ftag1 = 6'd2; step();
      fvalid = 2'b01; ftag0 = 6'd7; step();
      idle(); #2;
      total++; if (panic !== 1'b1) begin bad++; $display("FAIL err_panic got=%0b exp=1", panic); end
      total++; if (fcount !== 7'd59) begin bad++; $display("FAIL err_count got=%0d exp=59", fcount); end
      req = 2'b01; #2;
      total++; if (grant !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL err_block got=g%0b s%0b exp=g0 s1", grant, stall); end
      step(); idle();
      do_reset();
      req = 2'b01; #2;
      total++; if (panic !== 1'b0 || grant !== 1'b1) begin bad++; $display("FAIL err_cleared got=p%0b g%0b exp=p0 g1", panic, grant); end
      // full allocator: any free is an error and leaves the count alone
      req = 2'b00; fvalid = 2'b01; ftag0 = 6'd1;
      step(); idle(); #2;
      total++; if (panic !== 1'b1 || fcount !== 7'd63) begin bad++; $display("FAIL err_full_free got=p%0b c%0d exp=p1 c63", panic, fcount); end
   endtask

   task automatic test_halt();
      do_reset();
      halt = 1'b1; req = 2'b11; #2;
      total++; if (stall !== 1'b1 || grant !== 1'b0) begin bad++; $display("FAIL halt_stall got=s%0b g%0b exp=s1 g0", stall, grant); end
      step(); req = 2'b00; halt = 1'b0; #2;
      total++; if (fcount !== 7'd63 || tag0 !== 6'd1) begin bad++; $display("FAIL halt_nochange got=c%0d t%0d exp=c63 t1", fcount, tag0); end
      req = 2'b11; step();
      halt = 1'b1; req = 2'b11; fvalid = 2'b01; ftag0 = 6'd1; #2;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL halt_stall2 got=%0b exp=1", stall); end
      step(); idle(); #2;
      total++; if (fcount !== 7'd62 || panic !== 1'b0 || tag0 !== 6'd3) begin
         bad++; $display("FAIL halt_free got=c%0d p%0b t%0d exp=c62 p0 t3", fcount, panic, tag0);
      end
   endtask

   task automatic test_back_to_back();
      // state from test_halt: tag 2 outstanding, next offer 3
      req = 2'b01; fvalid = 2'b01; ftag0 = 6'd2; #2;
      total++; if (tag0 !== 6'd3 || grant !== 1'b1) begin bad++; $display("FAIL b2b_offer got=%0d g%0b exp=3 g1", tag0, grant); end
      step();
      fvalid = 2'b00; req = 2'b11; #2;
      total++; if (fcount !== 7'd62 || tag0 !== 6'd4 || tag1 !== 6'd5) begin
         bad++; $display("FAIL b2b_next got=c%0d (%0d,%0d) exp=c62 (4,5)", fcount, tag0, tag1);
      end
      step(); idle(); #2;
      total++; if (fcount !== 7'd60) begin bad++; $display("FAIL b2b_count got=%0d exp=60", fcount); end
   endtask

   initial begin
      test_reset();
      test_fill_empty();
      test_same_cycle();
      test_wrap();
      test_flush();
      test_errors();
      test_halt();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rename_allocator.md
RENAME_ALLOCATOR -- requirements
Module: rename_allocator

Parameters
REQ-001 TAGS, default 63, number of rename tags; valid tags are 1..TAGS, and tag 0 means "no rename".

Interface
REQ-002 i_clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 i_reset_n  in  1  synchronous, active-low reset.
REQ-004 i_alloc_req  in  2  bit k: rename slot k (instruction k of the decode pair) needs a tag.
REQ-005 o_alloc_tag_0, o_alloc_tag_1  out  6 each  tag offered to slot 0 / slot 1; combinational from registered state.
REQ-006 o_alloc_grant  out  1  high: every requested slot receives its offered tag this cycle.
REQ-007 o_stall  out  1  high: i_alloc_req is non-zero and o_alloc_grant is low.
REQ-008 i_free_valid  in  2  bit k: commit port k returns a tag this cycle.
REQ-009 i_free_tag_0, i_free_tag_1  in  6 each  tags returned by commit ports 0 / 1.
REQ-010 i_flush  in  1  mispredict flush; reclaims every outstanding tag.
REQ-011 i_halt  in  1  blocks new allocation; frees and flush still act.
REQ-012 o_free_count  out  7  registered number of free tags, 0..TAGS.
REQ-013 o_panic  out  1  sticky protocol-error flag.

Function
REQ-014 Tags are allocated and freed strictly in program order; state is alloc_ptr, free_ptr (0..TAGS-1) and free_count; the tag at pointer p is p+1.
REQ-015 Offers: o_alloc_tag_0 = alloc_ptr+1; o_alloc_tag_1 = (alloc_ptr+1 mod TAGS)+1 if req=2'b11, else alloc_ptr+1; pointers wrap TAGS-1 -> 0.
REQ-016 need = popcount(i_alloc_req); o_alloc_grant = !i_halt && !i_flush && !o_panic && need!=0 && free_count >= need, all-or-nothing (no partial grant).
REQ-017 On grant: alloc_ptr advances by need (mod TAGS) and free_count decreases by need at the next edge.
REQ-018 Frees: ports are processed in order, port 0 first; each valid free must carry tag free_ptr+1 (mod TAGS), which advances free_ptr by 1 and increases free_count by 1.
REQ-019 A free with a mismatched tag, or a free while outstanding = TAGS-free_count is 0, sets o_panic; that free is ignored and its pointers and count are unchanged.
REQ-020 Tags freed in cycle N are first offered no earlier than cycle N+1; the grant decision uses registered free_count only.
REQ-021 Simultaneous grant and frees: free_count_next = free_count - need + frees_accepted, which never exceeds TAGS.
REQ-022 Flush: frees in the same cycle are applied first; then alloc_ptr := free_ptr_after_frees and free_count := TAGS; no grant in a flush cycle.
REQ-023 i_halt=1: o_alloc_grant=0 and o_stall follows REQ-007; frees and flush behave normally.
REQ-024 Empty boundary: free_count=0 with any request gives o_stall=1; free_count=1 with req=2'b11 gives o_stall=1 and no tag consumed.
REQ-025 Full boundary: free_count=TAGS means alloc_ptr==free_ptr; any free in this state is a REQ-019 error.
REQ-026 Once set, o_panic holds until reset and suppresses all grants.

Reset
REQ-027 i_reset_n=0 at an edge: alloc_ptr=0, free_ptr=0, free_count=TAGS, o_panic=0; this takes priority over every other input.
REQ-028 Outputs after reset: o_alloc_tag_0=1, o_alloc_tag_1=1 (req 00), o_alloc_grant=0, o_stall=0, o_free_count=63.
REQ-029 Reset asserted mid-operation discards all outstanding tags; no free is required afterwards.

Verification
REQ-030 Reset, then req=11 for 31 cycles: tags (1,2)..(61,62) are granted and o_free_count=1; next req=11 gives o_stall=1; req=01 then gives tag 63 and o_free_count=0.
REQ-031 Wrap: after 62 alloc + 62 free, req=11 gives tags (63,1), and freeing 63 then 1 is accepted.
REQ-032 Same-cycle: free_count=0 and free tag 1 with req=01 gives a stall this cycle; next cycle tag 1 is offered, granted, and o_free_count returns to 0.
REQ-033 Flush: allocate tags 1..10, free 1..3, flush with a simultaneous free of 4: o_free_count=63 and the next grant offers tag 5.
REQ-034 Errors: freeing tag 7 when 3 is expected sets o_panic=1, which then blocks grants; reset clears it.
REQ-035 Halt: i_halt=1 with req=11 and free_count=63 gives o_stall=1 and no pointer change; a free during halt is still accepted.
